parc_core_reorder_buffer: RTL
=============================

Name: parc_core_reorder_buffer

Overview:
- 16-entry in-order reorder buffer for the 5-stage PARC core. It is the counterpart of the scoreboard's ROB interface.
- Decode allocates a slot per register-writing instruction; that slot index is what the scoreboard records per destination register.
- Writeback fills slots out of order. The head retires in order to the register file.
- Emits rob_commit_wen/rob_commit_slot, which the scoreboard uses to clear pending bits. Provides slot-indexed bypass data for the scoreboard's bypass-mux select 5.

Parameters:
- NUM_ENTRIES, 16, number of slots (power of two)
- SLOT_BITS, 4, log2(NUM_ENTRIES), width of slot indices

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rob_alloc_req_val  in  1  allocation request from decode
- rob_alloc_req_rdy  out  1  buffer can accept an allocation
- rob_alloc_req_preg  in  5  architectural destination register
- rob_alloc_req_spec  in  1  instruction lies in a branch shadow
- rob_alloc_resp_slot  out  4  slot granted this cycle (= tail)
- rob_fill_val  in  1  writeback result valid
- rob_fill_slot  in  4  slot being filled
- rob_fill_data  in  32  result value
- spec_resolve_val  in  1  outstanding branch resolved
- spec_resolve_squash  in  1  1 = mispredict (squash), 0 = confirm
- src0_byp_rob_slot  in  4  bypass read slot 0
- src0_byp_data  out  32  data of slot src0_byp_rob_slot
- src1_byp_rob_slot  in  4  bypass read slot 1
- src1_byp_data  out  32  data of slot src1_byp_rob_slot
- rob_commit_wen  out  1  head entry retires this cycle
- rob_commit_slot  out  4  slot retiring (= head)
- rob_commit_rf_wen  out  1  register-file write enable
- rob_commit_rf_waddr  out  5  register-file write address
- rob_commit_data  out  32  register-file write data

Behaviour:
- Per-entry state: valid, pending, spec, squashed, preg[4:0], data[31:0].
- Global state: head[3:0], tail[3:0], count[4:0] (0..16). Pointers wrap modulo 16.
- Reset: all valid/pending/spec/squashed cleared, head=tail=count=0. Entry data is not reset.
- Values immediately after reset: rob_alloc_req_rdy=1, rob_alloc_resp_slot=0, rob_commit_wen=0, rob_commit_rf_wen=0, rob_commit_slot=0.
- Reset has priority over every other input, including mid-operation.
- rdy = (count != 16). Combinational from registered count; a same-cycle commit does not free space.
- resp_slot = tail, combinational.
- Allocation fires on val && rdy at posedge:
  - entry[tail] gets valid=1, pending=1, spec=rob_alloc_req_spec, squashed=0, preg=rob_alloc_req_preg.
  - tail increments.
- Fill at posedge when rob_fill_val:
  - if entry[fill_slot].valid: data<=fill_data, pending<=0.
  - fill to an invalid slot is ignored.
  - multiple fills to the same slot: the last one wins.
- Resolve at posedge when spec_resolve_val:
  - every valid entry with spec=1 clears spec.
  - if squash=1 those entries also set squashed=1.
  - an entry allocated in the same cycle is unaffected and keeps its own alloc spec flag.
- Commit is combinational from registered head state:
  - rob_commit_wen = valid[head] && !pending[head] && !spec[head].
  - rob_commit_rf_wen = rob_commit_wen && !squashed[head] && preg[head]!=0.
  - waddr = preg[head], data = data[head].
  - On rob_commit_wen, at posedge: valid[head]<=0, head increments.
- Squashed entries still wait for their fill, because the instruction still reaches writeback, then retire without an RF write.
- count update: count += alloc_fire − rob_commit_wen. Simultaneous alloc and commit leaves count unchanged.
- Fill and commit of the same slot in one cycle: commit sees the pre-edge pending=1, so the entry retires next cycle at the earliest.
- Bypass reads: srcN_byp_data = data[srcN_byp_rob_slot], combinational, regardless of entry state. Same-cycle fill data is not forwarded.
- Throughput: 1 alloc, 1 fill, 1 commit per cycle.

Test Plan:
- Reset, then allocate preg 3, 5, 7 (spec=0) in consecutive cycles -> resp_slot 0,1,2. Fill slot 1 (0xBEEF) before slot 0 (0x1234) -> commit slot 0 (waddr 3, data 0x1234), then slot 1 (waddr 5, 0xBEEF), strictly in order; rdy stays 1.
- 16 allocations without commit -> rdy=0 after 16th, count=16. Alloc+commit same cycle at full -> no alloc accepted. Next cycle rdy=1; tail wraps to slot 0 and resp_slot=0.
- Allocate spec entry (preg 9), fill 0x55, resolve squash=1 -> rob_commit_wen=1 for that slot with rob_commit_rf_wen=0. Same with squash=0 -> rf_wen=1, waddr 9, data 0x55.
- Spec entry filled but unresolved at head -> no commit for 10 cycles; resolve in cycle 11 -> commit the following cycle. Entry allocated spec=1 in the resolve cycle stays spec.
- Fill slot 4 with 0xCAFE; set src0_byp_rob_slot=4 and src1_byp_rob_slot=4 -> both outputs 0xCAFE the cycle after fill. Fill to an invalid slot -> no state change.
- Assert reset with 6 entries outstanding -> next cycle count=0, rdy=1, commit_wen=0, resp_slot=0.

Source files
------------

// File: rtl/parc_core_reorder_buffer.sv
// parc_core_reorder_buffer: 16-entry in-order reorder buffer for the 5-stage PARC core.
// Latency: alloc/fill/resolve take effect at the next posedge; commit and bypass are combinational from state.
// Backpressure: rob_alloc_req_rdy drops when all slots are in use; fill/resolve/commit are never stalled.
// Ports: clk/reset (sync, active-high); rob_alloc_req_* / rob_alloc_resp_slot (decode allocation);
//   rob_fill_* (writeback); spec_resolve_* (branch resolution); srcN_byp_* (slot-indexed bypass reads);
//   rob_commit_* (in-order retirement to scoreboard and register file).
module parc_core_reorder_buffer #(
   parameter int NUM_ENTRIES = 16,
   parameter int SLOT_BITS   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rob_alloc_req_val,
   output logic                 rob_alloc_req_rdy,
   input  logic [4:0]           rob_alloc_req_preg,
   input  logic                 rob_alloc_req_spec,
   output logic [SLOT_BITS-1:0] rob_alloc_resp_slot,
   input  logic                 rob_fill_val,
   input  logic [SLOT_BITS-1:0] rob_fill_slot,
   input  logic [31:0]          rob_fill_data,
   input  logic                 spec_resolve_val,
   input  logic                 spec_resolve_squash,
   input  logic [SLOT_BITS-1:0] src0_byp_rob_slot,
   output logic [31:0]          src0_byp_data,
   input  logic [SLOT_BITS-1:0] src1_byp_rob_slot,
   output logic [31:0]          src1_byp_data,
   output logic                 rob_commit_wen,
   output logic [SLOT_BITS-1:0] rob_commit_slot,
   output logic                 rob_commit_rf_wen,
   output logic [4:0]           rob_commit_rf_waddr,
   output logic [31:0]          rob_commit_data
);

   localparam logic [SLOT_BITS:0] FULL = (SLOT_BITS+1)'(NUM_ENTRIES);

   logic [NUM_ENTRIES-1:0] valid;
   logic [NUM_ENTRIES-1:0] pending;
   logic [NUM_ENTRIES-1:0] spec;
   logic [NUM_ENTRIES-1:0] squashed;
   logic [4:0]             preg [NUM_ENTRIES];
   logic [31:0]            data [NUM_ENTRIES];

   logic [SLOT_BITS-1:0]   head;
   logic [SLOT_BITS-1:0]   tail;
   logic [SLOT_BITS:0]     count;

   logic                   alloc_fire;
   logic                   fill_hit;

   // Space is judged from the registered count only, so a retirement in the
   // same cycle never makes room for an allocation until the next cycle.
   assign rob_alloc_req_rdy   = (count != FULL);
   assign rob_alloc_resp_slot = tail;
   assign alloc_fire          = rob_alloc_req_val && rob_alloc_req_rdy;
   assign fill_hit            = rob_fill_val && valid[rob_fill_slot];

   // The head waits for its result and for any covering branch to resolve.
   // Squashed entries still drain in order, just without touching the RF.
   assign rob_commit_wen      = valid[head] && !pending[head] && !spec[head];
   assign rob_commit_slot     = head;
   assign rob_commit_rf_wen   = rob_commit_wen && !squashed[head] && (preg[head] != 5'd0);
   assign rob_commit_rf_waddr = preg[head];
   assign rob_commit_data     = data[head];

   // Raw array reads: the scoreboard only selects these for slots it knows are filled.
   assign src0_byp_data = data[src0_byp_rob_slot];
   assign src1_byp_data = data[src1_byp_rob_slot];

   always_ff @(posedge clk) begin
      if (reset) begin
         valid    <= '0;
         pending  <= '0;
         spec     <= '0;
         squashed <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         // Resolution acts on pre-edge valid/spec; the alloc write below comes
         // later and therefore wins for the slot allocated this cycle.
         if (spec_resolve_val) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
               if (valid[i] && spec[i]) begin
                  spec[i] <= 1'b0;
                  if (spec_resolve_squash)
                     squashed[i] <= 1'b1;
               end
            end
         end

         if (rob_commit_wen) begin
            valid[head] <= 1'b0;
            head        <= head + 1'b1;
         end

         // The tail slot is always invalid when an allocation fires, so this
         // never collides with the head retirement above.
         if (alloc_fire) begin
            valid[tail]    <= 1'b1;
            pending[tail]  <= 1'b1;
            spec[tail]     <= rob_alloc_req_spec;
            squashed[tail] <= 1'b0;
            tail           <= tail + 1'b1;
         end

         if (fill_hit)
            pending[rob_fill_slot] <= 1'b0;

         case ({alloc_fire, rob_commit_wen})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage carries no reset; only the control bits qualify it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (alloc_fire)
            preg[tail] <= rob_alloc_req_preg;
         if (fill_hit)
            data[rob_fill_slot] <= rob_fill_data;
      end
   end

endmodule
